// File: rtl/alsu_pkg.sv
// Shared ALSU command layout, opcodes and idle vector for the request scheduler.
package alsu_pkg;

    localparam int unsigned CMD_W           = 16;
    localparam int unsigned OPND_W          = 3;
    localparam int unsigned DATA_W          = 6;
    localparam int unsigned DEFAULT_LATENCY = 2;

    // Command field offsets
    localparam int unsigned A_LSB         = 0;
    localparam int unsigned B_LSB         = 3;
    localparam int unsigned OP_LSB        = 6;
    localparam int unsigned BYPASS_B_BIT  = 9;
    localparam int unsigned BYPASS_A_BIT  = 10;
    localparam int unsigned RED_OP_B_BIT  = 11;
    localparam int unsigned RED_OP_A_BIT  = 12;
    localparam int unsigned DIRECTION_BIT = 13;
    localparam int unsigned SERIAL_IN_BIT = 14;
    localparam int unsigned CIN_BIT       = 15;

    localparam logic [OPND_W-1:0] OP_AND    = 3'b000;
    localparam logic [OPND_W-1:0] OP_XOR    = 3'b001;
    localparam logic [OPND_W-1:0] OP_ADD    = 3'b010;
    localparam logic [OPND_W-1:0] OP_MUL    = 3'b011;
    localparam logic [OPND_W-1:0] OP_SHIFT  = 3'b100;
    localparam logic [OPND_W-1:0] OP_ROTATE = 3'b101;
    localparam logic [OPND_W-1:0] OP_IDLE   = 3'b110;

    // Bit layout matches the offsets above (first member is the MSB)
    typedef struct packed {
        logic              cin;
        logic              serial_in;
        logic              direction;
        logic              red_op_a;
        logic              red_op_b;
        logic              bypass_a;
        logic              bypass_b;
        logic [OPND_W-1:0] op;
        logic [OPND_W-1:0] b;
        logic [OPND_W-1:0] a;
    } alsu_cmd_t;

    typedef enum logic [1:0] {
        ARB_FREE  = 2'b00,
        ARB_LOCK0 = 2'b01,
        ARB_LOCK1 = 2'b10
    } arb_state_t;

    // Idle vector: given opcode, all operands and control bits zero
    function automatic logic [CMD_W-1:0] idle_vec(input logic [OPND_W-1:0] op);
        logic [CMD_W-1:0] v;
        v = '0;
        v[OP_LSB +: OPND_W] = op;
        return v;
    endfunction

    localparam logic [CMD_W-1:0] IDLE_VEC = idle_vec(OP_IDLE);

endpackage

// File: rtl/alsu_req_scheduler_if.sv
// Requester, ALSU-pin and response signals of the ALSU request scheduler.
interface alsu_req_scheduler_if;
    import alsu_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    alsu_cmd_t         req0_cmd;
    logic              req0_lock;
    logic              req1_valid;
    logic              req1_ready;
    alsu_cmd_t         req1_cmd;
    logic              req1_lock;

    logic [OPND_W-1:0] alsu_A;
    logic [OPND_W-1:0] alsu_B;
    logic [OPND_W-1:0] alsu_op;
    logic              alsu_cin;
    logic              alsu_serial_in;
    logic              alsu_direction;
    logic              alsu_red_op_A;
    logic              alsu_red_op_B;
    logic              alsu_bypass_A;
    logic              alsu_bypass_B;
    logic [DATA_W-1:0] alsu_out;

    logic              rsp_valid;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;

    // Scheduler side
    modport slave (
        input  req0_valid, req0_cmd, req0_lock,
        input  req1_valid, req1_cmd, req1_lock,
        input  alsu_out,
        output req0_ready, req1_ready,
        output alsu_A, alsu_B, alsu_op, alsu_cin, alsu_serial_in, alsu_direction,
        output alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B,
        output rsp_valid, rsp_id, rsp_data
    );

    // Requester / ALSU side
    modport master (
        output req0_valid, req0_cmd, req0_lock,
        output req1_valid, req1_cmd, req1_lock,
        output alsu_out,
        input  req0_ready, req1_ready,
        input  alsu_A, alsu_B, alsu_op, alsu_cin, alsu_serial_in, alsu_direction,
        input  alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B,
        input  rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/alsu_rr_arb.sv
// Two-way round-robin arbiter with a lock that pins the grant to one requester.
module alsu_rr_arb
    import alsu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic [1:0] lock,
    input  logic [1:0] hs,
    output logic [1:0] ready_c,
    output logic       grant_id_c
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       last_q;
    logic       last_d;

    // State and last-granted pointer; last=1 makes req0 win the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_FREE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Grant decode from state and valids
    always_comb begin
        ready_c = 2'b00;
        case (state_q)
            ARB_FREE: begin
                if (valid[0] && valid[1]) begin
                    ready_c = last_q ? 2'b01 : 2'b10;
                end else begin
                    ready_c = valid;
                end
            end
            ARB_LOCK0: ready_c[0] = valid[0];
            ARB_LOCK1: ready_c[1] = valid[1];
            default:   ready_c = 2'b00;
        endcase
        grant_id_c = ready_c[1];
    end

    // Next state: every handshake moves the pointer and sets or clears the lock
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (hs[0]) begin
            last_d  = 1'b0;
            state_d = lock[0] ? ARB_LOCK0 : ARB_FREE;
        end else if (hs[1]) begin
            last_d  = 1'b1;
            state_d = lock[1] ? ARB_LOCK1 : ARB_FREE;
        end
    end

endmodule

// File: rtl/alsu_req_scheduler.sv
// Issues arbitrated commands onto the ALSU pins and returns tagged results in order.
module alsu_req_scheduler
    import alsu_pkg::*;
#(
    parameter int unsigned       LATENCY = DEFAULT_LATENCY,
    parameter logic [OPND_W-1:0] IDLE_OP = OP_IDLE
) (
    input  logic                 clk,
    input  logic                 rst,
    alsu_req_scheduler_if.slave  bus
);

    localparam int unsigned      DEPTH = LATENCY + 1;
    localparam logic [CMD_W-1:0] IDLE  = idle_vec(IDLE_OP);

    logic [1:0]        valid;
    logic [1:0]        lock;
    logic [1:0]        ready_c;
    logic [1:0]        hs_c;
    logic              grant_id_c;
    logic              issue_c;
    logic [CMD_W-1:0]  grant_cmd_c;

    logic [CMD_W-1:0]  issue_q;
    logic [DEPTH-1:0]  trk_valid_q;
    logic [DEPTH-1:0]  trk_id_q;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_data_q;

    assign valid          = {bus.req1_valid, bus.req0_valid};
    assign lock           = {bus.req1_lock, bus.req0_lock};
    assign hs_c           = valid & ready_c;
    assign issue_c        = |hs_c;
    assign grant_cmd_c    = grant_id_c ? CMD_W'(bus.req1_cmd) : CMD_W'(bus.req0_cmd);
    assign bus.req0_ready = ready_c[0];
    assign bus.req1_ready = ready_c[1];

    alsu_rr_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .lock       (lock),
        .hs         (hs_c),
        .ready_c    (ready_c),
        .grant_id_c (grant_id_c)
    );

    // Issue register: accepted command for one cycle, idle vector otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_q <= IDLE;
        end else begin
            issue_q <= issue_c ? grant_cmd_c : IDLE;
        end
    end

    assign bus.alsu_A         = issue_q[A_LSB +: OPND_W];
    assign bus.alsu_B         = issue_q[B_LSB +: OPND_W];
    assign bus.alsu_op        = issue_q[OP_LSB +: OPND_W];
    assign bus.alsu_cin       = issue_q[CIN_BIT];
    assign bus.alsu_serial_in = issue_q[SERIAL_IN_BIT];
    assign bus.alsu_direction = issue_q[DIRECTION_BIT];
    assign bus.alsu_red_op_A  = issue_q[RED_OP_A_BIT];
    assign bus.alsu_red_op_B  = issue_q[RED_OP_B_BIT];
    assign bus.alsu_bypass_A  = issue_q[BYPASS_A_BIT];
    assign bus.alsu_bypass_B  = issue_q[BYPASS_B_BIT];

    // In-flight tracking: {valid, id} follows each command through the ALSU pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_valid_q <= '0;
            trk_id_q    <= '0;
        end else begin
            trk_valid_q <= {trk_valid_q[DEPTH-2:0], issue_c};
            trk_id_q    <= {trk_id_q[DEPTH-2:0], grant_id_c & issue_c};
        end
    end

    // Response register: capture the ALSU result when the tracked command reaches the tail
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= trk_valid_q[DEPTH-1];
            if (trk_valid_q[DEPTH-1]) begin
                rsp_id_q   <= trk_id_q[DEPTH-1];
                rsp_data_q <= bus.alsu_out;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alsu_req_scheduler.sv
// Randomized and directed bench for alsu_req_scheduler with a behavioural ALSU and scoreboard.
module tb_alsu_req_scheduler;
    import alsu_pkg::*;

    localparam logic [15:0] IDLE_EXP = 16'h0180;

    typedef struct {
        int         due;
        logic       id;
        logic [5:0] data;
    } exp_rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    alsu_req_scheduler_if bus ();

    alsu_req_scheduler #(.LATENCY(2), .IDLE_OP(3'b110)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          passed = 0;
    int          cyc    = 0;
    exp_rsp_t    exp_q[$];
    logic [6:0]  rsp_log[$];

    logic        m_last;
    logic        m_lock_on;
    logic        m_owner;
    logic        m_prev_hs;
    logic [5:0]  m_prev_res;
    logic [15:0] m_issue;

    // ALSU behaviour: shift/rotate act on the current output register
    function automatic logic [5:0] alsu_eval(input alsu_cmd_t c, input logic [5:0] prev);
        logic [5:0] r;
        logic       bad;
        bad = (c.op == 3'b110) || (c.op == 3'b111) ||
              ((c.red_op_a || c.red_op_b) && (c.op != 3'b000) && (c.op != 3'b001));
        r = 6'd0;
        if (bad)             r = 6'd0;
        else if (c.bypass_a) r = 6'(c.a);
        else if (c.bypass_b) r = 6'(c.b);
        else begin
            case (c.op)
                3'b000:  r = c.red_op_a ? 6'(&c.a) : (c.red_op_b ? 6'(&c.b) : 6'(c.a & c.b));
                3'b001:  r = c.red_op_a ? 6'(^c.a) : (c.red_op_b ? 6'(^c.b) : 6'(c.a ^ c.b));
                3'b010:  r = 6'(c.a) + 6'(c.b) + 6'(c.cin);
                3'b011:  r = 6'(c.a) * 6'(c.b);
                3'b100:  r = c.direction ? {prev[4:0], c.serial_in} : {c.serial_in, prev[5:1]};
                default: r = c.direction ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
            endcase
        end
        return r;
    endfunction

    // Environment ALSU: input register then output register
    alsu_cmd_t  pins;
    alsu_cmd_t  env_in_q;
    logic [5:0] env_out_q;

    assign pins = {bus.alsu_cin, bus.alsu_serial_in, bus.alsu_direction, bus.alsu_red_op_A,
                   bus.alsu_red_op_B, bus.alsu_bypass_A, bus.alsu_bypass_B,
                   bus.alsu_op, bus.alsu_B, bus.alsu_A};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            env_in_q  <= '0;
            env_out_q <= 6'd0;
        end else begin
            env_in_q  <= pins;
            env_out_q <= alsu_eval(env_in_q, env_out_q);
        end
    end

    assign bus.alsu_out = env_out_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [15:0] mk(input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] op, input logic [6:0] ctl);
        return {ctl, op, b, a};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_last     = 1'b1;
        m_lock_on  = 1'b0;
        m_owner    = 1'b0;
        m_prev_hs  = 1'b0;
        m_prev_res = 6'd0;
        m_issue    = IDLE_EXP;
    endtask

    // One clock cycle: check registered outputs, drive requests, check grants, advance the model
    task automatic step(input logic v0, input logic [15:0] c0, input logic l0,
                        input logic v1, input logic [15:0] c1, input logic l1);
        logic        e0, e1, id, lk, expv;
        logic [15:0] c;
        logic [5:0]  res;
        @(negedge clk);
        check("issue_vec", 32'(pins), 32'(m_issue));
        expv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("rsp_valid", 32'(bus.rsp_valid), 32'(expv));
        if (bus.rsp_valid) rsp_log.push_back({bus.rsp_id, bus.rsp_data});
        if (expv) begin
            check("rsp_id", 32'(bus.rsp_id), 32'(exp_q[0].id));
            check("rsp_data", 32'(bus.rsp_data), 32'(exp_q[0].data));
            void'(exp_q.pop_front());
        end
        bus.req0_valid = v0;
        bus.req0_cmd   = alsu_cmd_t'(c0);
        bus.req0_lock  = l0;
        bus.req1_valid = v1;
        bus.req1_cmd   = alsu_cmd_t'(c1);
        bus.req1_lock  = l1;
        #1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (m_lock_on) begin
            if (m_owner) e1 = v1;
            else         e0 = v0;
        end else if (v0 && v1) begin
            if (m_last) e0 = 1'b1;
            else        e1 = 1'b1;
        end else begin
            e0 = v0;
            e1 = v1;
        end
        check("hs0", 32'(bus.req0_valid & bus.req0_ready), 32'(e0));
        check("hs1", 32'(bus.req1_valid & bus.req1_ready), 32'(e1));
        if (e0 || e1) begin
            id  = e1;
            c   = e1 ? c1 : c0;
            lk  = e1 ? l1 : l0;
            res = alsu_eval(alsu_cmd_t'(c), m_prev_hs ? m_prev_res : 6'd0);
            exp_q.push_back('{cyc + 4, id, res});
            m_prev_res = res;
            m_prev_hs  = 1'b1;
            m_last     = id;
            m_lock_on  = lk;
            m_owner    = id;
            m_issue    = c;
        end else begin
            m_prev_hs = 1'b0;
            m_issue   = IDLE_EXP;
        end
        cyc++;
    endtask

    task automatic idle_step();
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic drain();
        repeat (6) idle_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_issue_vec", 32'(pins), 32'(IDLE_EXP));
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        cyc++;
        model_reset();
    endtask

    initial begin
        model_reset();
        bus.req0_valid = 1'b0;
        bus.req0_cmd   = '0;
        bus.req0_lock  = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req1_cmd   = '0;
        bus.req1_lock  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_issue_vec", 32'(pins), 32'(IDLE_EXP));
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
        rst = 1'b0;

        // ADD 3+4+cin from req0 alone
        rsp_log.delete();
        step(1'b1, mk(3'd3, 3'd4, 3'b010, 7'b1000000), 1'b0, 1'b0, 16'h0, 1'b0);
        drain();
        check("t1_count", 32'(rsp_log.size()), 32'd1);
        if (rsp_log.size() > 0) check("t1_rsp", 32'(rsp_log[0]), 32'({1'b0, 6'd8}));

        // Both valid, no locks: grants alternate starting with req0
        do_reset();
        rsp_log.delete();
        repeat (6) step(1'b1, 16'($urandom), 1'b0, 1'b1, 16'($urandom), 1'b0);
        drain();
        check("t2_count", 32'(rsp_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < rsp_log.size(); i++)
            check("t2_order", 32'(rsp_log[i][6]), 32'(i % 2));

        // req1 locked bypass then chained shift while req0 waits
        rsp_log.delete();
        step(1'b1, mk(3'd1, 3'd1, 3'b000, 7'b0), 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, mk(3'd1, 3'd2, 3'b000, 7'b0), 1'b0, 1'b1, mk(3'd5, 3'd0, 3'b000, 7'b0000010), 1'b1);
        step(1'b1, mk(3'd1, 3'd2, 3'b000, 7'b0), 1'b0, 1'b1, mk(3'd0, 3'd0, 3'b100, 7'b0110000), 1'b0);
        step(1'b1, mk(3'd1, 3'd2, 3'b000, 7'b0), 1'b0, 1'b0, 16'h0, 1'b0);
        drain();
        check("t3_count", 32'(rsp_log.size()), 32'd4);
        if (rsp_log.size() >= 4) begin
            check("t3_bypass", 32'(rsp_log[1]), 32'(7'b1_000101));
            check("t3_shift", 32'(rsp_log[2]), 32'(7'b1_001011));
            check("t3_release", 32'(rsp_log[3][6]), 32'd0);
        end

        // Shift and rotate after idle cycles see a zero operand
        rsp_log.delete();
        step(1'b1, mk(3'd0, 3'd0, 3'b100, 7'b0110000), 1'b0, 1'b0, 16'h0, 1'b0);
        repeat (3) idle_step();
        step(1'b1, mk(3'd7, 3'd7, 3'b101, 7'b0), 1'b0, 1'b0, 16'h0, 1'b0);
        drain();
        check("t4_count", 32'(rsp_log.size()), 32'd2);
        if (rsp_log.size() >= 2) begin
            check("t4_shift", 32'(rsp_log[0][5:0]), 32'(6'b000001));
            check("t4_rotate", 32'(rsp_log[1][5:0]), 32'(6'b000000));
        end

        // MUL 7*7 and an undefined opcode
        rsp_log.delete();
        step(1'b1, mk(3'd7, 3'd7, 3'b011, 7'b0), 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, mk(3'd7, 3'd7, 3'b111, 7'b0), 1'b0, 1'b0, 16'h0, 1'b0);
        drain();
        check("t5_count", 32'(rsp_log.size()), 32'd2);
        if (rsp_log.size() >= 2) begin
            check("t5_mul", 32'(rsp_log[0][5:0]), 32'(6'd49));
            check("t5_op7", 32'(rsp_log[1][5:0]), 32'd0);
        end

        // Reset two cycles after a handshake discards it; next tie goes to req0
        rsp_log.delete();
        step(1'b1, mk(3'd2, 3'd2, 3'b010, 7'b0), 1'b0, 1'b0, 16'h0, 1'b0);
        idle_step();
        do_reset();
        step(1'b1, mk(3'd1, 3'd1, 3'b010, 7'b0), 1'b0, 1'b1, mk(3'd3, 3'd3, 3'b010, 7'b0), 1'b0);
        drain();
        check("t6_count", 32'(rsp_log.size()), 32'd1);
        if (rsp_log.size() > 0) check("t6_rsp", 32'(rsp_log[0]), 32'({1'b0, 6'd2}));

        // Random traffic with locks and one mid-run reset
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            step(($urandom_range(3) != 0), 16'($urandom), ($urandom_range(3) == 0),
                 ($urandom_range(3) != 0), 16'($urandom), ($urandom_range(3) == 0));
        end
        drain();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/alsu_req_scheduler.md
# alsu_req_scheduler

Two-requester command scheduler sitting in front of the ALSU. It arbitrates round-robin between two command sources and issues at most one command per cycle onto the ALSU's registered inputs. It tracks in-flight commands through the ALSU's fixed pipeline and returns each 6-bit result, tagged with the requester id, in issue order. A lock mechanism lets one requester issue uninterrupted back-to-back bursts, which shift/rotate chains need because they operate on the ALSU's previous result.

## Interface

Parameters:
- LATENCY, 2, cycles from ALSU input pins to a valid ALSU `out`; covers the ALSU's input register plus its output register.
- IDLE_OP, 3'b110, opcode driven when nothing is issued; the ALSU forces `out` to 0 for this opcode.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req0_valid / req1_valid  in  1  command present
- req0_ready / req1_ready  out  1  grant; combinational from arbiter state and valids
- req0_cmd / req1_cmd  in  16  fields: [2:0] A, [5:3] B, [8:6] op, [15:9] {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B}
- req0_lock / req1_lock  in  1  keep grant after this command
- alsu_A, alsu_B, alsu_op  out  3 each  to ALSU A_r/B_r/op_r; registered
- alsu_cin, alsu_serial_in, alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B  out  1 each  registered
- alsu_out  in  6  ALSU result
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_id  out  1  requester that issued the command
- rsp_data  out  6  captured alsu_out

## Operation

- **Handshake.** `reqN_valid & reqN_ready` sampled at a clock edge means the command is accepted. At most one ready is high per cycle.
- **Arbitration, unlocked.**
  - Only one valid: that requester gets ready.
  - Both valid: grant the requester not granted last.
  - rr pointer updates on every handshake.
- **Lock.**
  - A handshake with `reqN_lock = 1` locks the grant to N. Only N may receive ready, even in cycles where N is not valid.
  - The lock is released by a handshake from N with `lock = 0`.
- **Issue.**
  - An accepted command drives the `alsu_*` registers for exactly one cycle.
  - Any cycle with no handshake drives the idle vector: op = IDLE_OP, A = B = 0, all control bits 0.
- **Tracking.** A shift register LATENCY+1 deep carries {valid, id} per issued command. At its tail, `alsu_out` is registered into `rsp_data`, with `rsp_valid` and `rsp_id` set.
- **Ordering.** Responses are strictly in issue order; at most one response per cycle.
- **Shift/rotate operand.** Shift/rotate commands act on whatever ALSU `out` holds:
  - the previous command's result if issued in the immediately preceding cycle;
  - 0 after any idle cycle.
  - Requesters needing chains use lock with back-to-back valids.
- **`leds`.** Not consumed.

## Timing

- **Reset values:**
  - `alsu_*` hold the idle vector.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0.
  - rr pointer set so req0 wins the first tie.
  - Lock cleared; tracking register cleared.
- **Latency.** Handshake in cycle k:
  - command on `alsu_*` in k+1;
  - ALSU `out` valid in k+3;
  - rsp_valid high in k+4 (LATENCY+2 total).
- **Throughput.** One command per cycle sustained.
- **Simultaneous issue and response.** Allowed every cycle.
- **Lock holder stalls.** The ALSU gets idle vectors, `out` becomes 0, and any chain is broken. This is permitted; the requester is responsible.
- **Reset mid-flight.** All in-flight commands are discarded and no rsp_valid is produced for them. The lock is dropped.
- **Arithmetic.** All results fit in 6 bits: 7*7 = 49, 7+7+1 = 15. No truncation is handled here.

## Structure

- Shared package `alsu_pkg`:
  - cmd field offsets and width (16);
  - opcode constants (AND 000, XOR 001, ADD 010, MUL 011, SHIFT 100, ROTATE 101, IDLE 110);
  - idle-vector constant;
  - default LATENCY.
- Sub-module `alsu_rr_arb`: 2-way round-robin with lock; inputs valids/locks/handshake, outputs readys and grant id.
- Top holds the issue registers, the tracking shift register and the response register.

## Test plan

1. req0 only, cmd A=3, B=4, op=010, cin=1, handshake in cycle k → rsp_valid in k+4, rsp_data=8, rsp_id=0.
2. Both valid every cycle, no locks, 6 commands → grants alternate 0,1,0,1,0,1; six consecutive responses in the same order.
3. req1 locked burst, back-to-back:
   - bypass_A A=5, lock=1, then shift direction=1 serial_in=1, lock=0 → responses 000101 then 001011, both id 1;
   - req0 held valid gets no ready until the lock is released.
4. Standalone shift after idle cycles, direction=1 serial_in=1 → rsp_data=000001. Rotate direction=0 after idle → 000000.
5. MUL A=7, B=7 → rsp_data=110001. op=111 → rsp_data=0.
6. Handshake in k, rst pulsed in k+2 → no rsp_valid ever for that command; `alsu_*` show the idle vector; the next tie goes to req0.
